fetch_unit: RTL
===============

# fetch_unit

Parametrised instruction-fetch stage that generalises the single-cycle PC/PC+4/branch-mux path into a decoupled front end. It owns the program counter, reads a combinational instruction memory, and queues fetched words with their PC and parity bit in a small buffer. Decode drains the buffer through a valid/ready handshake. Branch/jump redirects from the execute stage flush the buffer and reload the PC.

## Interface
Parameters:
- XLEN, 32, width of PC, instruction word and redirect target.
- BUF_DEPTH, 4, buffer entries; power of two, minimum 2.
- RESET_PC, 0, PC value loaded on reset; must be 4-byte aligned.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- fetch_en  in  1  fetch permitted this cycle; low = hold PC and push nothing.
- imem_addr  out  XLEN  fetch address, equal to the PC register; combinational from state.
- imem_data  in  XLEN  instruction word at imem_addr, valid in the same cycle.
- redirect_valid  in  1  execute-stage branch/jump taken this cycle.
- redirect_target  in  XLEN  new PC; bits [1:0] ignored (treated as 0).
- redirect_misalign  out  1  registered one-cycle pulse: previous-cycle redirect had target[1:0] != 0.
- out_valid  out  1  buffer head holds an entry.
- out_ready  in  1  decode accepts the head entry.
- out_pc  out  XLEN  PC of the head entry.
- out_instr  out  XLEN  instruction of the head entry.
- out_parity  out  1  XOR reduction of out_instr.
- buf_count  out  $clog2(BUF_DEPTH)+1  current number of buffered entries.

## Operation
- Pop: occurs when out_valid && out_ready. Removes the head entry.
- Push: occurs when fetch_en && !redirect_valid && (buf_count < BUF_DEPTH || pop). Writes {pc, imem_data, ^imem_data} at the tail and sets pc <= pc + 4.
- PC arithmetic is modulo 2^XLEN. PC 2^XLEN-4 increments to 0 with no flag.
- Redirect has priority over every other event:
  - pc <= {redirect_target[XLEN-1:2], 2'b00}.
  - All entries are flushed; buf_count <= 0.
  - No push occurs that cycle.
  - A pop handshake in the same cycle still counts as consumed by decode.
- redirect_misalign <= redirect_valid && |redirect_target[1:0]. The redirect itself proceeds with the aligned target.
- Full buffer, no pop: no push; PC holds. imem_addr stays stable.
- Full buffer with a same-cycle pop: push and pop both occur; count is unchanged.
- Empty buffer: out_valid = 0. out_pc, out_instr and out_parity hold their last values and must not be interpreted. There is no pass-through, so a word fetched this cycle appears at the output the next cycle.
- fetch_en low: no push and PC holds. Pops continue.

## Timing
- Reset (async assert, sync-safe deassert):
  - pc = RESET_PC, buf_count = 0, out_valid = 0.
  - out_pc = 0, out_instr = 0, out_parity = 0.
  - redirect_misalign = 0.
  - Storage contents are don't-care.
- Fetch-to-output latency is 1 cycle. The word at PC p pushed at edge N is visible with out_valid at cycle N+1.
- Redirect sampled at edge N: buffer is empty and imem_addr = target during cycle N+1. The target instruction is pushed at edge N+1 and is on out_instr in cycle N+2.
- Reset asserted mid-operation: immediate return to reset values. Any in-flight entries are lost.
- Steady state with out_ready held high: one instruction per cycle.

## Structure
- Package fetch_pkg holds:
  - constant PC_STEP = 4;
  - fetch_entry_t struct {pc, instr, parity};
  - a parity function (XOR reduction).
- One sub-module, fetch_fifo:
  - parametrised on depth and entry type;
  - circular buffer with rd/wr pointers carrying an extra wrap bit;
  - ports push, pop, flush, count, head.
- fetch_unit holds the PC register, the push/pop/redirect arbitration and the misalign flag.

## Test plan
- Reset and free-run:
  - Stimulus: RESET_PC=0, fetch_en=1, out_ready=1, imem returning addr^32'hA5A5_0000.
  - Required: out_pc = 0,4,8,… from cycle 1, one per cycle; out_parity matches ^out_instr.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles.
  - Required: buf_count saturates at 4; imem_addr freezes at 16. Releasing out_ready drains pcs 0,4,8,12 in order, then 16, with no duplicates or gaps.
- Redirect while full:
  - Stimulus: buffer full, redirect_target=0x100 with out_ready=1 the same cycle.
  - Required: next cycle buf_count=0 and imem_addr=0x100; following cycle out_pc=0x100.
- Misaligned redirect:
  - Stimulus: target 0x203.
  - Required: redirect_misalign pulses for 1 cycle; fetch resumes at 0x200.
- Wrap-around:
  - Stimulus: redirect to 0xFFFF_FFFC.
  - Required: out_pc = 0xFFFF_FFFC followed by 0x0000_0000.
- Mid-run reset:
  - Stimulus: assert rst asynchronously between edges with 3 entries buffered.
  - Required: out_valid and buf_count drop to 0 immediately; imem_addr = RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
package fetch_pkg;

    localparam int PC_STEP  = 4;
    localparam int XLEN_DEF = 32;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] instr;
        logic                parity;
    } fetch_entry_t;

    // Even parity (XOR reduction); narrower words are zero-extended by the caller.
    function automatic logic parity64(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer for fetched entries. Pointers carry an extra wrap bit so
// full and empty are distinguished without a separate counter.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  logic     pop,
    input  logic     flush,
    input  entry_t   wr_data,
    output entry_t   head,
    output logic [AW:0] count
);

    entry_t        mem_q [DEPTH];
    logic [AW:0]   wr_q;
    logic [AW:0]   rd_q;

    // Storage needs no reset; only slots between rd and wr are ever observed.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_q[AW-1:0]] <= wr_data;
        end
    end

    // Pointer update; flush empties the buffer regardless of push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (flush) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + (AW+1)'(1);
            if (pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    assign count = wr_q - rd_q;
    assign head  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch stage: PC register, push/pop/redirect
// arbitration into a small entry buffer, and the misaligned-redirect flag.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              BUF_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    localparam int             CW        = $clog2(BUF_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            redirect_misalign,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic            out_parity,
    output logic [CW-1:0]   buf_count
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            parity;
    } entry_t;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_q;
    entry_t          last_q;
    entry_t          head;
    entry_t          out_entry;
    entry_t          wr_entry;
    logic            pop;
    logic            push;
    logic            full;

    assign pop  = out_valid && out_ready;
    assign full = (buf_count == CW'(BUF_DEPTH));
    // A pop frees a slot in the same cycle, so a full buffer can still accept.
    assign push = fetch_en && !redirect_valid && (!full || pop);

    assign wr_entry = '{pc: pc_q, instr: imem_data, parity: parity64(64'(imem_data))};

    fetch_fifo #(
        .DEPTH   (BUF_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .wr_data (wr_entry),
        .head    (head),
        .count   (buf_count)
    );

    // Next PC: redirect wins, otherwise advance only when a word is pushed.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_target[XLEN-1:2], 2'b00};
        end else if (push) begin
            pc_d = pc_q + XLEN'(PC_STEP);
        end
    end

    // PC, misalign pulse and the last-shown output entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
            last_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= redirect_valid && (|redirect_target[1:0]);
            last_q     <= out_entry;
        end
    end

    // When empty, outputs freeze on whatever the head showed last.
    assign out_valid = (buf_count != '0);
    assign out_entry = out_valid ? head : last_q;

    assign imem_addr         = pc_q;
    assign out_pc            = out_entry.pc;
    assign out_instr         = out_entry.instr;
    assign out_parity        = out_entry.parity;
    assign redirect_misalign = misalign_q;

endmodule
